// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// MUL/MULHU use a shift-add accumulator. DIVU/REMU use a restoring divider.
// Every operation takes a fixed DATA_WIDTH iterations.
// The pipeline is held through `stall` until the result is ready.
module muldiv_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dst_in,
  input  logic                      flush,
  output logic                      busy,
  output logic                      stall,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_ADDR_WIDTH-1:0] dst_out,
  output logic                      div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_count;
  // The accumulator is shared by both operation types.
  // Multiply: {partial product high, multiplier bits still to consume}.
  // Divide:   {partial remainder, dividend bits shifting into the quotient}.
  logic [2*W-1:0]            r_acc;
  logic [W-1:0]              r_opnd;      // multiplicand or divisor
  logic [1:0]                r_op;
  logic [REG_ADDR_WIDTH-1:0] r_dst;
  logic                      r_dbz_pend;
  logic                      r_done;
  logic [W-1:0]              r_result;
  logic [REG_ADDR_WIDTH-1:0] r_dst_out;
  logic                      r_dbz;

  logic                      w_accept;
  logic [W-1:0]              w_addend;
  logic [W:0]                w_mul_sum;
  logic [W:0]                w_div_shift;
  logic [W:0]                w_div_diff;
  logic                      w_div_ge;
  logic [2*W-1:0]            w_acc_next;
  logic [W-1:0]              w_result_next;

  // A new operation may enter from IDLE or DONE. A flush always blocks it.
  assign w_accept = start & ~flush & (r_state != S_RUN);

  assign busy        = (r_state == S_RUN);
  assign stall       = (r_state == S_RUN) | (start & (r_state != S_RUN) & ~flush);
  assign done        = r_done;
  assign result      = r_result;
  assign dst_out     = r_dst_out;
  assign div_by_zero = r_dbz;

  // One iteration of either algorithm.
  // With a zero divisor the restoring divider naturally produces an all-ones
  // quotient and leaves the dividend as the remainder.
  always_comb begin
    w_addend    = r_acc[0] ? r_opnd : '0;
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
    w_div_shift = r_acc[2*W-1:W-1];
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    if (r_op[1]) begin
      w_acc_next = {(w_div_ge ? w_div_diff[W-1:0] : w_div_shift[W-1:0]),
                    r_acc[W-2:0], w_div_ge};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[W-1:1]};
    end
    // op[0] selects the high half: MULHU gives the product high word,
    // REMU gives the remainder.
    w_result_next = r_op[0] ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0];
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_op       <= '0;
      r_dst      <= '0;
      r_dbz_pend <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_dst_out  <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state    <= S_RUN;
            r_count    <= CW'(W);
            r_op       <= op;
            r_dst      <= dst_in;
            r_opnd     <= op[1] ? operand_b : operand_a;
            r_acc      <= {{W{1'b0}}, (op[1] ? operand_a : operand_b)};
            r_dbz_pend <= op[1] & (operand_b == '0);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (flush) begin
            // Abort: previously completed result, tag and flag stay visible.
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_result  <= w_result_next;
              r_dst_out <= r_dst;
              r_dbz     <= r_dbz_pend;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH=16, REG_ADDR_WIDTH=3).
module tb_muldiv_unit;
  localparam int W  = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [RW-1:0] dst_in = '0;
  logic          busy, stall, done, div_by_zero;
  logic [W-1:0]  result;
  logic [RW-1:0] dst_out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .dst_in(dst_in), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result),
    .dst_out(dst_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on unsigned operands.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    case (o)
      2'd0:    return W'(p % (64'd1 << W));
      2'd1:    return W'(p >> W);
      2'd2:    return (y == 0) ? {W{1'b1}} : W'(x / y);
      default: return (y == 0) ? x : W'(x % y);
    endcase
  endfunction

  // Wait for done, counting edges since the start cycle. The caller has
  // already advanced one cycle past the start cycle.
  task automatic wait_done(output int lat, output logic stall_ok);
    lat = 1;
    stall_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!stall || !busy) stall_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  // Issue one op from IDLE/DONE and check the whole transaction.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [RW-1:0] d,
                        input logic [W-1:0] exp_res, input logic exp_dbz);
    int   lat;
    logic sok;
    op = o; a = x; b = y; dst_in = d; start = 1'b1;
    #1;
    check({tag, " stall_at_start"}, stall, 1);
    step();
    start = 1'b0;
    wait_done(lat, sok);
    check({tag, " stall_during_run"}, sok, 1);
    check({tag, " latency"}, lat, W + 1);
    check({tag, " result"}, result, exp_res);
    check({tag, " div_by_zero"}, div_by_zero, exp_dbz);
    check({tag, " dst_out"}, dst_out, d);
    check({tag, " stall_in_done"}, stall, 0);
    step();
    check({tag, " done_one_cycle"}, done, 0);
    $display("[TB] %s op=%0d a=0x%0h b=0x%0h -> result=0x%0h dbz=%0b lat=%0d",
             tag, o, x, y, result, div_by_zero, lat);
  endtask

  initial begin
    int            lat;
    logic          sok;
    logic [1:0]    ro;
    logic [W-1:0]  rx, ry;
    logic [RW-1:0] rd;

    vecs[0] = '{2'd0, 16'd300,  16'd500,  16'h49F0, 1'b0};
    vecs[1] = '{2'd1, 16'd300,  16'd500,  16'h0002, 1'b0};
    vecs[2] = '{2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0};
    vecs[3] = '{2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0};
    vecs[4] = '{2'd2, 16'd1000, 16'd7,    16'd142,  1'b0};
    vecs[5] = '{2'd3, 16'd1000, 16'd7,    16'd6,    1'b0};
    vecs[6] = '{2'd2, 16'd1234, 16'd0,    16'hFFFF, 1'b1};
    vecs[7] = '{2'd3, 16'd1234, 16'd0,    16'h04D2, 1'b1};
    vecs[8] = '{2'd2, 16'hFFFF, 16'd1,    16'hFFFF, 1'b0};
    vecs[9] = '{2'd3, 16'd5,    16'd9,    16'd5,    1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset stall", stall, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset dst_out", dst_out, 0);
    check("reset dbz", div_by_zero, 0);
    reset_n = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, RW'(i),
             vecs[i].res, vecs[i].dbz);
    end

    // Back-to-back: DIVU then REMU started in the DONE cycle
    op = 2'd2; a = 16'd1000; b = 16'd7; dst_in = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, sok);
    check("b2b first latency", lat, 17);
    check("b2b first result", result, 142);
    op = 2'd3; dst_in = 3'd6; start = 1'b1;
    #1;
    check("b2b stall in done with start", stall, 1);
    step();
    start = 1'b0;
    check("b2b busy no gap", busy, 1);
    wait_done(lat, sok);
    check("b2b second latency", lat, 17);
    check("b2b second result", result, 6);
    check("b2b second dst", dst_out, 6);
    check("b2b second stall_run", sok, 1);
    $display("[TB] b2b divu/remu 1000/7 -> result=0x%0h", result);
    step();

    // Flush during RUN, then flush+start ignored, then new DIVU at cycle 8
    op = 2'd0; a = 16'd300; b = 16'd500; dst_in = 3'd1; start = 1'b1;   // cycle 0
    step();                                                              // cycle 1
    start = 1'b0;
    repeat (4) step();                                                   // cycle 5
    flush = 1'b1;
    step();                                                              // cycle 6
    flush = 1'b0;
    check("flush busy low", busy, 0);
    check("flush stall low", stall, 0);
    check("flush no done c6", done, 0);
    check("flush result kept", result, 6);
    step();                                                              // cycle 7
    check("flush no done c7", done, 0);
    start = 1'b1; flush = 1'b1;
    #1;
    check("flush+start stall", stall, 0);
    step();                                                              // cycle 8
    start = 1'b0; flush = 1'b0;
    check("flush+start ignored", busy, 0);
    check("flush dst kept", dst_out, 6);
    $display("[TB] flush sequence result=0x%0h", result);
    run_op("post_flush_divu", 2'd2, 16'd100, 16'd10, 3'd4, 16'd10, 1'b0);

    // Flush and start during DONE: done still pulses, start is ignored
    op = 2'd0; a = 16'd7; b = 16'd9; dst_in = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, sok);
    flush = 1'b1; start = 1'b1;
    #1;
    check("flush_in_done done", done, 1);
    check("flush_in_done stall", stall, 0);
    step();
    flush = 1'b0; start = 1'b0;
    check("flush_in_done result", result, 63);
    check("flush_in_done not busy", busy, 0);
    $display("[TB] flush in done 7*9 -> result=0x%0h", result);

    // Asynchronous reset in the middle of a DIVU
    run_op("pre_reset_div0", 2'd2, 16'd77, 16'd0, 3'd7, 16'hFFFF, 1'b1);
    op = 2'd2; a = 16'd50; b = 16'd5; dst_in = 3'd3; start = 1'b1;     // cycle 0
    step();
    start = 1'b0;
    repeat (8) step();                                                   // cycle 9
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset result", result, 0);
    check("midreset dbz", div_by_zero, 0);
    check("midreset dst_out", dst_out, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    step();
    reset_n = 1'b1;
    sok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) sok = 1'b0;
    end
    check("midreset no later done", sok, 1);
    $display("[TB] mid-op reset result=0x%0h", result);
    run_op("after_reset_mul", 2'd0, 16'd3, 16'd4, 3'd2, 16'd12, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      ry = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(1, 15));
      rd = RW'($urandom);
      run_op($sformatf("rand%0d", i), ro, rx, ry, rd, model(ro, rx, ry),
             ro[1] && (ry == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
